digest_serializer: RTL

//  Output stage of the SHA-2 core: takes a final hash state (8 x 64-bit H words) and emits the digest bytes as an AXI4-Stream packet.
//  - Byte order: MSB of H0 first; stream byte 0 is on tdata[7:0].
//  - Width is parametrised (64..512); the digest is spread over ceil(len/BYTES) beats.
//  - tkeep is set on the final beat; tuser is captured once per digest and repeated on every beat.

---
 rtl/digest_serializer_pkg.sv | 65 ++++++
 rtl/digest_serializer_pack.sv | 24 ++
 rtl/digest_serializer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/digest_serializer_pkg.sv
// digest_pkg: shared definitions for the SHA-2 digest serializer.
// It provides the SHA type codes, the FSM state encoding and the helpers
// for digest length and beat count.
// Optional feature macro: DIGEST_SHA512T_EN. When it is defined, codes
// 100/101 produce truncated SHA-512/224 and SHA-512/256 digests.
package digest_pkg;

    // SHA type codes as presented on sha_type
    localparam logic [2:0] SHA_224     = 3'b000;
    localparam logic [2:0] SHA_256     = 3'b001;
    localparam logic [2:0] SHA_384     = 3'b010;
    localparam logic [2:0] SHA_512     = 3'b011;
    localparam logic [2:0] SHA_512_224 = 3'b100;
    localparam logic [2:0] SHA_512_256 = 3'b101;

    // Serializer FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // SHA-224/256 carry 32-bit H words in the low half of each 64-bit lane
    function automatic logic is_word32(input logic [2:0] sha_type);
        return (sha_type == SHA_224) || (sha_type == SHA_256);
    endfunction

    // Digest length in bytes. Reserved codes fall back to a full SHA-512 digest.
    function automatic logic [6:0] digest_len_bytes(input logic [2:0] sha_type);
        logic [6:0] len;
        case (sha_type)
            SHA_224:     len = 7'd28;
            SHA_256:     len = 7'd32;
            SHA_384:     len = 7'd48;
            SHA_512:     len = 7'd64;
`ifdef DIGEST_SHA512T_EN
            SHA_512_224: len = 7'd28;
            SHA_512_256: len = 7'd32;
`else
            SHA_512_224,
            SHA_512_256: len = 7'd64;
`endif
            default:     len = 7'd64;
        endcase
        return len;
    endfunction

    // Number of output beats: ceil(len / bytes). Every digest length is non-zero,
    // so the result is always at least 1.
    function automatic logic [3:0] num_beats(input logic [6:0] len, input int bytes);
        int n;
        n = (int'(len) + bytes - 1) / bytes;
        return 4'(n);
    endfunction

    // Byte-enable pattern for the final beat: the low (len - (nb-1)*bytes) bits are set.
    function automatic logic [63:0] last_keep_mask(input logic [6:0] len, input int bytes);
        int rem;
        rem = int'(len) - (int'(num_beats(len, bytes)) - 1) * bytes;
        if (rem >= 64) begin
            return '1;
        end
        return (64'd1 << rem) - 64'd1;
    endfunction

endpackage

// File: rtl/digest_serializer_pack.sv
// digest_pack: reorders the 8 x 64-bit hash state into a little-endian byte
// stream where stream byte 0 is the most significant byte of H0.
// Purely combinational; one generate iteration per output byte.
module digest_pack (
    input  logic [511:0] state_i,
    input  logic         word64_i,
    output logic [511:0] stream_o
);

    for (genvar k = 0; k < 64; k++) begin : g_byte
        // 64-bit packing: byte k is byte (7 - k%8) of H[k/8]
        localparam int W64_LSB = 64 * (k / 8) + 8 * (7 - (k % 8));
        if (k < 32) begin : g_lo
            // 32-bit packing: byte k is byte (3 - k%4) of H[k/4][31:0]
            localparam int W32_LSB = 64 * (k / 4) + 8 * (3 - (k % 4));
            assign stream_o[8*k +: 8] = word64_i ? state_i[W64_LSB +: 8]
                                                 : state_i[W32_LSB +: 8];
        end else begin : g_hi
            // A 32-bit-word digest never reaches beyond byte 31
            assign stream_o[8*k +: 8] = word64_i ? state_i[W64_LSB +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/digest_serializer.sv
// digest_serializer: output stage of the SHA-2 core. It accepts one final
// hash state per transfer and emits the digest as an AXI4-Stream packet of
// ceil(LEN/BYTES) beats. tuser is captured once and repeated on every beat.
// tkeep trims the final beat, and bytes beyond the digest length are zero.
// Optional feature macro: DIGEST_SHA512T_EN (SHA-512/224 and SHA-512/256).
//
// Handshake: a transfer occurs on a rising edge of axi_aclk where valid and
// ready are both high. m_axis_tvalid never depends on m_axis_tready. While
// m_axis_tvalid is high and ready is low, tdata/tkeep/tlast/tuser hold.
// s_axis_tready is high only in IDLE, so a new state is accepted on the
// cycle after the last beat's handshake and never on the same cycle.
module digest_serializer
    import digest_pkg::*;
#(
    parameter int S_AXIS_DATA_WIDTH  = 512,
    parameter int M_AXIS_DATA_WIDTH  = 128,
    parameter int S_AXIS_TUSER_WIDTH = 128,
    parameter int M_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            axi_aclk,
    input  logic                            reset,
    input  logic [2:0]                      sha_type,
    input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output state_e                          dbg_state_o
);

    localparam int BYTES = M_AXIS_DATA_WIDTH / 8;

    // Registered state
    state_e                          state_q;
    logic [511:0]                    buf_q;
    logic [3:0]                      nb_q;
    logic [3:0]                      beat_q;
    logic [BYTES-1:0]                last_keep_q;
    logic [S_AXIS_TUSER_WIDTH-1:0]   tuser_q;
    logic                            tvalid_q;
    logic                            tlast_q;
    logic [BYTES-1:0]                tkeep_q;

    // Next-state values and accept-time decode
    logic [511:0]                    buf_d;
    logic [3:0]                      beat_d;
    logic                            last_d;
    logic                            word64;
    logic [6:0]                      in_len;
    logic [3:0]                      in_nb;
    logic [BYTES-1:0]                in_last_keep;
    logic [511:0]                    packed_stream;
    logic [511:0]                    masked_stream;

    // Each accepted transfer is exactly one digest, so tlast on the input is meaningless
    logic unused_s_tlast;
    assign unused_s_tlast = s_axis_tlast;

    digest_pack u_pack (
        .state_i  (s_axis_tdata),
        .word64_i (word64),
        .stream_o (packed_stream)
    );

    // Decode the incoming mode and zero every stream byte past the digest length
    always_comb begin
        word64        = !is_word32(sha_type);
        in_len        = digest_len_bytes(sha_type);
        in_nb         = num_beats(in_len, BYTES);
        in_last_keep  = BYTES'(last_keep_mask(in_len, BYTES));
        masked_stream = '0;
        for (int k = 0; k < 64; k++) begin
            masked_stream[8*k +: 8] = (7'(k) < in_len) ? packed_stream[8*k +: 8] : 8'h00;
        end
    end

    // Advance values used on a beat handshake
    always_comb begin
        buf_d  = buf_q >> M_AXIS_DATA_WIDTH;
        beat_d = beat_q + 4'd1;
        last_d = (beat_d == (nb_q - 4'd1));
    end

    // Serializer FSM: latch a digest in IDLE, stream it out beat by beat in SEND
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            nb_q        <= '0;
            beat_q      <= '0;
            last_keep_q <= '0;
            tuser_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tkeep_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        buf_q       <= masked_stream;
                        nb_q        <= in_nb;
                        beat_q      <= '0;
                        last_keep_q <= in_last_keep;
                        tuser_q     <= s_axis_tuser;
                        tvalid_q    <= 1'b1;
                        tlast_q     <= (in_nb == 4'd1);
                        tkeep_q     <= (in_nb == 4'd1) ? in_last_keep : '1;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (m_axis_tready) begin
                        buf_q <= buf_d;
                        if (tlast_q) begin
                            // Final beat consumed: drop the stream and wait for the next digest
                            beat_q   <= '0;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            tkeep_q  <= '0;
                            state_q  <= ST_IDLE;
                        end else begin
                            beat_q  <= beat_d;
                            tlast_q <= last_d;
                            tkeep_q <= last_d ? last_keep_q : '1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_axis_tready = (state_q == ST_IDLE);
    assign m_axis_tdata  = buf_q[M_AXIS_DATA_WIDTH-1:0];
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign dbg_state_o   = state_q;

endmodule
